// File: rtl/key_req_latch_if.sv
`default_nettype none
// ============================================================================
// Module      : key_req_latch_if
// Description : Bundles the key inputs, the consumer acknowledge and the
//               request/enable outputs of key_req_latch.
//               master : drives key_raw/ack, observes req_vec/en_n/busy
//               slave  : the latch itself
//   key_raw  N_CH  raw key levels, 1 = pressed, asynchronous to clk
//   ack      1     consumer has taken the current request (1-cycle pulse)
//   req_vec  N_CH  held press vector presented to the encoder
//   en_n     1     encoder enable, active-low, 0 while req_vec is valid
//   busy     1     1 while the request FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface key_req_latch_if #(
    parameter int N_CH = 8
);
    logic [N_CH-1:0] key_raw;
    logic            ack;
    logic [N_CH-1:0] req_vec;
    logic            en_n;
    logic            busy;

    modport master (
        output key_raw,
        output ack,
        input  req_vec,
        input  en_n,
        input  busy
    );

    modport slave (
        input  key_raw,
        input  ack,
        output req_vec,
        output en_n,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/key_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : key_req_latch
// Description : Synchronises and debounces N_CH raw push-button lines,
//               captures press events (0->1 of the debounced level) into a
//               pending mask and presents them as a held request vector with
//               an active-low enable until the consumer acknowledges.
// Ports       : clk    - system clock, rising edge
//               rst_n  - synchronous reset, active-low
//               bus    - key_req_latch_if.slave (key_raw, ack -> req_vec,
//                        en_n, busy)
// Parameters  : N_CH   - number of key channels
//               DB_CYC - clocks a synchronised level must persist (>=2)
//               CNT_W  - debounce counter width, 2**CNT_W > DB_CYC
// Revision    : 1.0 - initial release
// ============================================================================
module key_req_latch #(
    parameter int N_CH   = 8,
    parameter int DB_CYC = 20,
    parameter int CNT_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_req_latch_if.slave       bus
);

    localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DB_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N_CH-1:0] w_press;
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] r_req_vec;
    logic            r_en_n;
    logic            r_busy;

    // ------------------------------------------------------------------
    // Per-channel synchroniser and debouncer
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic             r_meta;
            logic             r_sync;
            logic             r_stable;
            logic [CNT_W-1:0] r_cnt;
            logic             w_differ;
            logic             w_accept;

            assign w_differ = (r_sync != r_stable);
            assign w_accept = w_differ && (r_cnt == c_DB_LAST);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_meta   <= 1'b0;
                    r_sync   <= 1'b0;
                    r_stable <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_meta <= bus.key_raw[gi];
                    r_sync <= r_meta;
                    if (!w_differ) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        r_stable <= r_sync;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Accepting a new level of 1 is exactly a 0->1 update of stable.
            assign w_press[gi] = w_accept && r_sync;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pending mask and request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_req_vec <= '0;
            r_en_n    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= r_pending | w_press;
            case (r_state)
                IDLE: begin
                    if (r_pending != '0) begin
                        r_req_vec <= r_pending;
                        // Only the snapshotted bits are cleared; a press
                        // landing on this same edge survives for next round.
                        r_pending <= w_press;
                        r_en_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ack) begin
                        r_req_vec <= '0;
                        r_en_n    <= 1'b1;
                        r_state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_req_vec <= '0;
                    r_en_n    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_vec = r_req_vec;
    assign bus.en_n    = r_en_n;
    assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_key_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_req_latch
// Description : Self-checking bench for key_req_latch (DB_CYC=4). A directed
//               vector table covers reset, clean press, bounce, accumulation,
//               snapshot race and mid-operation reset; a randomized phase
//               follows. Every cycle is also compared against a sliding-
//               window reference model of the debouncer and request protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_req_latch;

    localparam int N_CH   = 8;
    localparam int DB_CYC = 4;
    localparam int CNT_W  = 3;

    localparam int c_PH_IDLE = 0;
    localparam int c_PH_PRES = 1;
    localparam int c_PH_REL  = 2;

    logic clk;
    logic rst_n;

    key_req_latch_if #(.N_CH(N_CH)) bus ();

    key_req_latch #(
        .N_CH   (N_CH),
        .DB_CYC (DB_CYC),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // ------------------------------------------------------------------
    // Reference model: a level is accepted once the last DB_CYC
    // synchronised samples (raw delayed by two edges) all disagree with it.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] m_hist [0:DB_CYC+1];
    logic [N_CH-1:0] m_stable;
    logic [N_CH-1:0] m_pend;
    logic [N_CH-1:0] m_req;
    int              m_phase;

    task automatic model_edge();
        logic [N_CH-1:0] all1;
        logic [N_CH-1:0] all0;
        logic [N_CH-1:0] press;
        logic [N_CH-1:0] old_pend;
        if (!rst_n) begin
            for (int j = 0; j <= DB_CYC + 1; j++) m_hist[j] = '0;
            m_stable = '0;
            m_pend   = '0;
            m_req    = '0;
            m_phase  = c_PH_IDLE;
        end else begin
            for (int j = DB_CYC + 1; j >= 1; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = bus.key_raw;
            all1 = '1;
            all0 = '1;
            for (int j = 2; j <= DB_CYC + 1; j++) begin
                all1 &= m_hist[j];
                all0 &= ~m_hist[j];
            end
            press    = all1 & ~m_stable;
            m_stable = (m_stable | press) & ~(all0 & m_stable);
            old_pend = m_pend;
            m_pend   = old_pend | press;
            case (m_phase)
                c_PH_IDLE: if (old_pend != '0) begin
                    m_req   = old_pend;
                    m_pend  = press;
                    m_phase = c_PH_PRES;
                end
                c_PH_PRES: if (bus.ack) begin
                    m_req   = '0;
                    m_phase = c_PH_REL;
                end
                default: m_phase = c_PH_IDLE;
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_req_vec", 32'(bus.req_vec), 32'(m_req));
        chk("model_en_n", 32'(bus.en_n), 32'(m_phase != c_PH_PRES));
        chk("model_busy", 32'(bus.busy), 32'(m_phase != c_PH_IDLE));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs held for ncyc clocks, then outputs
    // compared against hand-derived values.
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] raw;
        logic       ack;
        logic       rstn;
        int         ncyc;
        logic [7:0] req;
        logic       en_n;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [7:0] r, input logic a, input logic rs,
                                input int n, input logic [7:0] q, input logic e,
                                input logic b);
        vec_t v;
        v.raw = r; v.ack = a; v.rstn = rs; v.ncyc = n;
        v.req = q; v.en_n = e; v.busy = b;
        tbl.push_back(v);
    endfunction

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.key_raw = '0;
        bus.ack     = 1'b0;
        m_stable = '0; m_pend = '0; m_req = '0; m_phase = c_PH_IDLE;
        for (int j = 0; j <= DB_CYC + 1; j++) m_hist[j] = '0;

        // 1. reset with keys held, then release reset
        add(8'hFF, 0, 0, 3, 8'h00, 1, 0);
        add(8'hFF, 0, 1, 6, 8'h00, 1, 0);
        add(8'hFF, 0, 1, 1, 8'hFF, 0, 1);
        add(8'hFF, 1, 1, 1, 8'h00, 1, 1);
        add(8'hFF, 0, 1, 1, 8'h00, 1, 0);
        add(8'h00, 0, 1, 10, 8'h00, 1, 0);
        // 2. clean press on key 2
        add(8'h04, 0, 1, 6, 8'h00, 1, 0);
        add(8'h04, 0, 1, 1, 8'h04, 0, 1);
        add(8'h04, 0, 1, 3, 8'h04, 0, 1);
        add(8'h04, 1, 1, 1, 8'h00, 1, 1);
        add(8'h04, 0, 1, 1, 8'h00, 1, 0);
        add(8'h00, 0, 1, 10, 8'h00, 1, 0);
        // 3. bounce on key 5, then stick
        for (int k = 0; k < 5; k++) begin
            add(8'h20, 0, 1, 2, 8'h00, 1, 0);
            add(8'h00, 0, 1, 2, 8'h00, 1, 0);
        end
        add(8'h20, 0, 1, 6, 8'h00, 1, 0);
        add(8'h20, 0, 1, 1, 8'h20, 0, 1);
        add(8'h20, 1, 1, 1, 8'h00, 1, 1);
        add(8'h20, 0, 1, 1, 8'h00, 1, 0);
        add(8'h00, 0, 1, 10, 8'h00, 1, 0);
        // 4. accumulate keys 3 and 6 while presenting key 0
        add(8'h01, 0, 1, 7, 8'h01, 0, 1);
        add(8'h49, 0, 1, 7, 8'h01, 0, 1);
        add(8'h49, 1, 1, 1, 8'h00, 1, 1);
        add(8'h49, 0, 1, 1, 8'h00, 1, 0);
        add(8'h49, 0, 1, 1, 8'h48, 0, 1);
        add(8'h49, 1, 1, 1, 8'h00, 1, 1);
        add(8'h00, 0, 1, 10, 8'h00, 1, 0);
        // 5. key 1 accepted on the very edge that snapshots 8'h10
        add(8'h01, 0, 1, 7, 8'h01, 0, 1);
        add(8'h11, 0, 1, 6, 8'h01, 0, 1);
        add(8'h13, 0, 1, 3, 8'h01, 0, 1);
        add(8'h13, 1, 1, 1, 8'h00, 1, 1);
        add(8'h13, 0, 1, 1, 8'h00, 1, 0);
        add(8'h13, 0, 1, 1, 8'h10, 0, 1);
        add(8'h13, 1, 1, 1, 8'h00, 1, 1);
        add(8'h13, 0, 1, 1, 8'h00, 1, 0);
        add(8'h13, 0, 1, 1, 8'h02, 0, 1);
        add(8'h13, 1, 1, 1, 8'h00, 1, 1);
        add(8'h00, 0, 1, 10, 8'h00, 1, 0);
        // 6. reset for one clock while presenting, keys already released
        add(8'h80, 0, 1, 7, 8'h80, 0, 1);
        add(8'h00, 0, 1, 3, 8'h80, 0, 1);
        add(8'h00, 0, 0, 1, 8'h00, 1, 0);
        add(8'h00, 0, 1, 12, 8'h00, 1, 0);

        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].ncyc; c++) begin
                bus.key_raw = tbl[k].raw;
                bus.ack     = tbl[k].ack;
                rst_n       = tbl[k].rstn;
                step();
            end
            chk($sformatf("tbl%0d_req_vec", k), 32'(bus.req_vec), 32'(tbl[k].req));
            chk($sformatf("tbl%0d_en_n", k), 32'(bus.en_n), 32'(tbl[k].en_n));
            chk($sformatf("tbl%0d_busy", k), 32'(bus.busy), 32'(tbl[k].busy));
        end
        bus.ack = 1'b0;
        rst_n   = 1'b1;

        // Randomized phase: sparse key flips (including short glitches),
        // random ack pulses and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0)
                bus.key_raw = bus.key_raw ^ (8'd1 << $urandom_range(0, 7));
            bus.ack = ($urandom_range(0, 3) == 0);
            rst_n   = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
